// File: rtl/alu_share_arb.sv
// alu_share_arb: round-robin sharing of one combinational ALU between two requesters.
// Define ALU_ARB_STATS_EN to add saturating grant/conflict counters.
module alu_share_arb #(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_req_valid_0,
    input  logic             i_req_valid_1,
    output logic             o_req_ready_0,
    output logic             o_req_ready_1,
    input  logic [31:0]      i_req_op1_0,
    input  logic [31:0]      i_req_op1_1,
    input  logic [31:0]      i_req_op2_0,
    input  logic [31:0]      i_req_op2_1,
    input  logic [2:0]       i_req_uop_0,
    input  logic [2:0]       i_req_uop_1,
    input  logic             i_req_f7_0,
    input  logic             i_req_f7_1,
    input  logic [TAG_W-1:0] i_req_tag_0,
    input  logic [TAG_W-1:0] i_req_tag_1,
    output logic             o_rsp_valid_0,
    output logic             o_rsp_valid_1,
    input  logic             i_rsp_ready_0,
    input  logic             i_rsp_ready_1,
    output logic [31:0]      o_rsp_out_0,
    output logic [31:0]      o_rsp_out_1,
    output logic             o_rsp_zero_0,
    output logic             o_rsp_zero_1,
    output logic [TAG_W-1:0] o_rsp_tag_0,
    output logic [TAG_W-1:0] o_rsp_tag_1,
    output logic [31:0]      o_alu_op1,
    output logic [31:0]      o_alu_op2,
    output logic [2:0]       o_alu_uop,
    output logic             o_alu_f7,
    input  logic [31:0]      i_alu_out,
`ifdef ALU_ARB_STATS_EN
    input  logic             i_stat_clr,
    output logic [15:0]      o_stat_grant_0,
    output logic [15:0]      o_stat_grant_1,
    output logic [15:0]      o_stat_conflict,
`endif
    input  logic             i_alu_zero
);
    logic             r_prio;
    logic             r_rsp_valid_0, r_rsp_valid_1;
    logic [31:0]      r_rsp_out_0, r_rsp_out_1;
    logic             r_rsp_zero_0, r_rsp_zero_1;
    logic [TAG_W-1:0] r_rsp_tag_0, r_rsp_tag_1;
    logic             w_elig_0, w_elig_1, w_gnt_0, w_gnt_1;

    // A full slot may still accept a new result when it is being drained this cycle.
    assign w_elig_0 = i_req_valid_0 & (~r_rsp_valid_0 | i_rsp_ready_0);
    assign w_elig_1 = i_req_valid_1 & (~r_rsp_valid_1 | i_rsp_ready_1);
    assign w_gnt_0  = rst_n & w_elig_0 & (~w_elig_1 | ~r_prio);
    assign w_gnt_1  = rst_n & w_elig_1 & (~w_elig_0 | r_prio);

    assign o_req_ready_0 = w_gnt_0;
    assign o_req_ready_1 = w_gnt_1;
    assign o_alu_op1 = w_gnt_0 ? i_req_op1_0 : w_gnt_1 ? i_req_op1_1 : 32'd0;
    assign o_alu_op2 = w_gnt_0 ? i_req_op2_0 : w_gnt_1 ? i_req_op2_1 : 32'd0;
    assign o_alu_uop = w_gnt_0 ? i_req_uop_0 : w_gnt_1 ? i_req_uop_1 : 3'd0;
    assign o_alu_f7  = w_gnt_0 ? i_req_f7_0  : w_gnt_1 ? i_req_f7_1  : 1'b0;

    assign o_rsp_valid_0 = r_rsp_valid_0;
    assign o_rsp_valid_1 = r_rsp_valid_1;
    assign o_rsp_out_0   = r_rsp_out_0;
    assign o_rsp_out_1   = r_rsp_out_1;
    assign o_rsp_zero_0  = r_rsp_zero_0;
    assign o_rsp_zero_1  = r_rsp_zero_1;
    assign o_rsp_tag_0   = r_rsp_tag_0;
    assign o_rsp_tag_1   = r_rsp_tag_1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_prio        <= 1'b0;
            r_rsp_valid_0 <= 1'b0;
            r_rsp_valid_1 <= 1'b0;
            r_rsp_out_0   <= '0;
            r_rsp_out_1   <= '0;
            r_rsp_zero_0  <= 1'b0;
            r_rsp_zero_1  <= 1'b0;
            r_rsp_tag_0   <= '0;
            r_rsp_tag_1   <= '0;
        end else begin
            if (w_gnt_0 | w_gnt_1) r_prio <= w_gnt_0;
            if (w_gnt_0) begin
                r_rsp_valid_0 <= 1'b1;
                r_rsp_out_0   <= i_alu_out;
                r_rsp_zero_0  <= i_alu_zero;
                r_rsp_tag_0   <= i_req_tag_0;
            end else if (i_rsp_ready_0) begin
                r_rsp_valid_0 <= 1'b0;
            end
            if (w_gnt_1) begin
                r_rsp_valid_1 <= 1'b1;
                r_rsp_out_1   <= i_alu_out;
                r_rsp_zero_1  <= i_alu_zero;
                r_rsp_tag_1   <= i_req_tag_1;
            end else if (i_rsp_ready_1) begin
                r_rsp_valid_1 <= 1'b0;
            end
        end
    end

`ifdef ALU_ARB_STATS_EN
    logic [15:0] r_stat_g0, r_stat_g1, r_stat_cf;
    logic        w_conf;

    assign w_conf = i_req_valid_0 & i_req_valid_1 & (w_gnt_0 ^ w_gnt_1);
    assign o_stat_grant_0  = r_stat_g0;
    assign o_stat_grant_1  = r_stat_g1;
    assign o_stat_conflict = r_stat_cf;

    always_ff @(posedge clk) begin
        if (!rst_n || i_stat_clr) begin
            r_stat_g0 <= '0;
            r_stat_g1 <= '0;
            r_stat_cf <= '0;
        end else begin
            r_stat_g0 <= r_stat_g0 + {15'd0, w_gnt_0 & ~&r_stat_g0};
            r_stat_g1 <= r_stat_g1 + {15'd0, w_gnt_1 & ~&r_stat_g1};
            r_stat_cf <= r_stat_cf + {15'd0, w_conf & ~&r_stat_cf};
        end
    end
`endif
endmodule

// File: tb/tb_alu_share_arb.sv
// tb_alu_share_arb: directed and randomized checks of alu_share_arb against a
// transaction-level model; the ALU itself is emulated behaviourally here.
module tb_alu_share_arb;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        rq_v[2], rq_f[2], rs_r[2], rdy[2], rs_v[2], rs_z[2];
    logic [31:0] rq_a[2], rq_b[2], rs_o[2];
    logic [2:0]  rq_u[2];
    logic [3:0]  rq_t[2], rs_t[2];
    logic [31:0] alu_op1, alu_op2, alu_out;
    logic [2:0]  alu_uop;
    logic        alu_f7, alu_zero;
    int          total = 0, bad = 0;

    // transaction-level model: one result slot per requester plus the fairness pointer
    logic        m_v[2], m_z[2];
    logic [31:0] m_o[2];
    logic [3:0]  m_t[2];
    int          m_prio;

`ifdef ALU_ARB_STATS_EN
    logic        stat_clr = 1'b0;
    logic [15:0] sg0, sg1, scf;
`endif

    function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] u, input logic f);
        case (u)
            3'd0: return f ? a - b : a + b;
            3'd1: return a << b[4:0];
            3'd2: return {31'd0, $signed(a) < $signed(b)};
            3'd3: return {31'd0, a < b};
            3'd4: return a ^ b;
            3'd5: begin
                if (f) return $signed(a) >>> b[4:0];
                return a >> b[4:0];
            end
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    assign alu_out  = alu_ref(alu_op1, alu_op2, alu_uop, alu_f7);
    assign alu_zero = (alu_out == 32'd0);

    alu_share_arb #(.TAG_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req_valid_0(rq_v[0]), .i_req_valid_1(rq_v[1]),
        .o_req_ready_0(rdy[0]), .o_req_ready_1(rdy[1]),
        .i_req_op1_0(rq_a[0]), .i_req_op1_1(rq_a[1]),
        .i_req_op2_0(rq_b[0]), .i_req_op2_1(rq_b[1]),
        .i_req_uop_0(rq_u[0]), .i_req_uop_1(rq_u[1]),
        .i_req_f7_0(rq_f[0]), .i_req_f7_1(rq_f[1]),
        .i_req_tag_0(rq_t[0]), .i_req_tag_1(rq_t[1]),
        .o_rsp_valid_0(rs_v[0]), .o_rsp_valid_1(rs_v[1]),
        .i_rsp_ready_0(rs_r[0]), .i_rsp_ready_1(rs_r[1]),
        .o_rsp_out_0(rs_o[0]), .o_rsp_out_1(rs_o[1]),
        .o_rsp_zero_0(rs_z[0]), .o_rsp_zero_1(rs_z[1]),
        .o_rsp_tag_0(rs_t[0]), .o_rsp_tag_1(rs_t[1]),
        .o_alu_op1(alu_op1), .o_alu_op2(alu_op2), .o_alu_uop(alu_uop), .o_alu_f7(alu_f7),
        .i_alu_out(alu_out),
`ifdef ALU_ARB_STATS_EN
        .i_stat_clr(stat_clr), .o_stat_grant_0(sg0), .o_stat_grant_1(sg1), .o_stat_conflict(scf),
`endif
        .i_alu_zero(alu_zero)
    );

    // Which requester the rules say wins with the inputs as they stand now.
    function automatic logic [1:0] ref_grant();
        bit e[2];
        if (!rst_n) return 2'b00;
        for (int i = 0; i < 2; i++) e[i] = rq_v[i] && (!m_v[i] || rs_r[i]);
        if (e[0] && e[1]) return (m_prio == 0) ? 2'b01 : 2'b10;
        return {e[1], e[0]};
    endfunction

    task automatic tick();
        logic [1:0] g;
        g = ref_grant();
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_v[i] = 0; m_o[i] = 0; m_z[i] = 0; m_t[i] = 0; m_prio = 0;
            end else if (g[i]) begin
                m_v[i] = 1;
                m_o[i] = alu_ref(rq_a[i], rq_b[i], rq_u[i], rq_f[i]);
                m_z[i] = (m_o[i] == 0);
                m_t[i] = rq_t[i];
                m_prio = 1 - i;
            end else if (rs_r[i]) begin
                m_v[i] = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] u, input logic f, input logic [3:0] t);
        rq_v[i] = 1; rq_a[i] = a; rq_b[i] = b; rq_u[i] = u; rq_f[i] = f; rq_t[i] = t;
    endtask

    task automatic do_reset();
        rst_n = 0;
        tick();
        rst_n = 1;
    endtask

    task automatic test_reset();
        rq_v[0] = 1; rq_v[1] = 1;
        #1;
        total++;
        if (rdy[0] !== 0 || rdy[1] !== 0) begin bad++; $display("FAIL reset_ready got=%b%b exp=00", rdy[1], rdy[0]); end
        tick();
        rq_v[0] = 0; rq_v[1] = 0;
        tick();
        total++;
        if (rs_v[0] !== 0 || rs_v[1] !== 0 || rs_o[0] !== 0 || rs_o[1] !== 0 || rs_z[0] !== 0 || rs_t[1] !== 0) begin
            bad++; $display("FAIL reset_state v=%b%b o0=%h o1=%h", rs_v[1], rs_v[0], rs_o[0], rs_o[1]);
        end
        rst_n = 1;
    endtask

    task automatic test_single();
        set_req(0, 5, 7, 3'd0, 0, 4'h9);
        #1;
        total++;
        if (rdy[0] !== 1 || rdy[1] !== 0 || alu_op1 !== 5 || alu_op2 !== 7) begin
            bad++; $display("FAIL single_grant rdy=%b%b op1=%h op2=%h", rdy[1], rdy[0], alu_op1, alu_op2);
        end
        tick();
        rq_v[0] = 0;
        #1;
        total++;
        if (rs_v[0] !== 1 || rs_o[0] !== 12 || rs_z[0] !== 0 || rs_t[0] !== 4'h9) begin
            bad++; $display("FAIL single_rsp v=%b out=%0d z=%b tag=%h exp 1/12/0/9", rs_v[0], rs_o[0], rs_z[0], rs_t[0]);
        end
        total++;
        if (alu_op1 !== 0 || alu_uop !== 0 || alu_f7 !== 0) begin
            bad++; $display("FAIL idle_mux op1=%h uop=%0d f7=%b exp 0", alu_op1, alu_uop, alu_f7);
        end
        rs_r[0] = 1;
        tick();
        rs_r[0] = 0;
        total++;
        if (rs_v[0] !== 0) begin bad++; $display("FAIL single_drain got=%b exp=0", rs_v[0]); end
    endtask

    task automatic test_alternate();
        do_reset();
        rs_r[0] = 1; rs_r[1] = 1;
        set_req(0, 32'h10, 32'h20, 3'd0, 0, 4'h1);
        set_req(1, 3, 3, 3'd0, 1, 4'h5);
        for (int k = 0; k < 4; k++) begin
            #1;
            total++;
            if (rdy[k % 2] !== 1 || rdy[1 - k % 2] !== 0) begin
                bad++; $display("FAIL alternate_%0d rdy=%b%b exp winner=%0d", k, rdy[1], rdy[0], k % 2);
            end
            tick();
            if (k == 1) begin
                total++;
                if (rs_v[1] !== 1 || rs_o[1] !== 0 || rs_z[1] !== 1 || rs_t[1] !== 4'h5) begin
                    bad++; $display("FAIL sub_zero v=%b out=%h z=%b tag=%h", rs_v[1], rs_o[1], rs_z[1], rs_t[1]);
                end
            end
        end
        rq_v[0] = 0; rq_v[1] = 0;
        tick();
    endtask

    task automatic test_blocked();
        do_reset();
        rs_r[0] = 0; rs_r[1] = 1;
        set_req(0, 1, 1, 3'd0, 0, 4'h1);
        tick();
        set_req(0, 2, 2, 3'd0, 0, 4'h2);
        set_req(1, 32'hF0, 32'h0F, 3'd6, 0, 4'h7);
        for (int k = 0; k < 3; k++) begin
            #1;
            total++;
            if (rdy[0] !== 0 || rdy[1] !== 1) begin bad++; $display("FAIL blocked_%0d rdy=%b%b exp=10", k, rdy[1], rdy[0]); end
            tick();
            total++;
            if (rs_v[0] !== 1 || rs_o[0] !== 2 || rs_t[0] !== 4'h1) begin
                bad++; $display("FAIL blocked_hold_%0d v=%b out=%0d exp 1/2", k, rs_v[0], rs_o[0]);
            end
        end
        rs_r[0] = 1;
        #1;
        total++;
        if (rdy[0] !== 1 || rdy[1] !== 0) begin bad++; $display("FAIL unblock rdy=%b%b exp=01", rdy[1], rdy[0]); end
        tick();
        rq_v[0] = 0; rs_r[0] = 0;
        total++;
        if (rs_v[0] !== 1 || rs_o[0] !== 4 || rs_t[0] !== 4'h2) begin
            bad++; $display("FAIL unblock_rsp v=%b out=%0d tag=%h exp 1/4/2", rs_v[0], rs_o[0], rs_t[0]);
        end
        rq_v[1] = 0; rs_r[0] = 1; rs_r[1] = 1;
        tick();
    endtask

    task automatic test_drain_grant();
        do_reset();
        rs_r[1] = 0;
        set_req(1, 32'h8000_0000, 4, 3'd5, 1, 4'h3);
        tick();
        total++;
        if (rs_v[1] !== 1 || rs_o[1] !== 32'hF800_0000) begin
            bad++; $display("FAIL sra v=%b out=%h exp 1/f8000000", rs_v[1], rs_o[1]);
        end
        set_req(1, 32'h8000_0000, 8, 3'd5, 1, 4'h4);
        rs_r[1] = 1;
        #1;
        total++;
        if (rdy[1] !== 1) begin bad++; $display("FAIL drain_grant_ready got=%b exp=1", rdy[1]); end
        tick();
        rq_v[1] = 0;
        total++;
        if (rs_v[1] !== 1 || rs_o[1] !== 32'hFF80_0000 || rs_t[1] !== 4'h4) begin
            bad++; $display("FAIL drain_grant_rsp v=%b out=%h tag=%h exp 1/ff800000/4", rs_v[1], rs_o[1], rs_t[1]);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        rs_r[0] = 0; rs_r[1] = 0;
        set_req(0, 9, 1, 3'd0, 1, 4'hA);
        set_req(1, 6, 6, 3'd7, 0, 4'hB);
        tick();
        tick();
        total++;
        if (rs_v[0] !== 1 || rs_v[1] !== 1) begin bad++; $display("FAIL mid_fill v=%b%b exp=11", rs_v[1], rs_v[0]); end
        rst_n = 0;
        #1;
        total++;
        if (rdy[0] !== 0 || rdy[1] !== 0) begin bad++; $display("FAIL mid_reset_ready rdy=%b%b exp=00", rdy[1], rdy[0]); end
        tick();
        total++;
        if (rs_v[0] !== 0 || rs_v[1] !== 0 || rs_o[0] !== 0 || rs_o[1] !== 0 ||
            rs_z[0] !== 0 || rs_z[1] !== 0 || rs_t[0] !== 0 || rs_t[1] !== 0) begin
            bad++; $display("FAIL mid_reset_state v=%b%b o0=%h o1=%h t=%h/%h", rs_v[1], rs_v[0], rs_o[0], rs_o[1], rs_t[0], rs_t[1]);
        end
        rst_n = 1;
        rs_r[0] = 1; rs_r[1] = 1;
        #1;
        total++;
        if (rdy[0] !== 1 || rdy[1] !== 0) begin bad++; $display("FAIL post_reset_prio rdy=%b%b exp=01", rdy[1], rdy[0]); end
        tick();
        rq_v[0] = 0; rq_v[1] = 0;
        tick();
    endtask

    task automatic new_req(input int i);
        logic [31:0] a;
        a = $urandom;
        set_req(i, a, ($urandom_range(3) == 0) ? a : $urandom, 3'($urandom_range(7)),
                1'($urandom_range(1)), 4'($urandom_range(15)));
    endtask

    task automatic test_random();
        logic [1:0]  g;
        logic [31:0] ea, eb;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (!rq_v[i] && $urandom_range(2) != 0) new_req(i);
                rs_r[i] = ($urandom_range(3) != 0);
            end
            g = ref_grant();
            ea = g[0] ? rq_a[0] : g[1] ? rq_a[1] : 32'd0;
            eb = g[0] ? rq_b[0] : g[1] ? rq_b[1] : 32'd0;
            #1;
            total++;
            if ({rdy[1], rdy[0]} !== g || alu_op1 !== ea || alu_op2 !== eb) begin
                bad++; $display("FAIL rand_grant c=%0d rdy=%b%b exp=%b op1=%h exp=%h op2=%h exp=%h",
                                c, rdy[1], rdy[0], g, alu_op1, ea, alu_op2, eb);
            end
            for (int i = 0; i < 2; i++) begin
                total++;
                if (rs_v[i] !== m_v[i] || (m_v[i] && (rs_o[i] !== m_o[i] || rs_z[i] !== m_z[i] || rs_t[i] !== m_t[i]))) begin
                    bad++; $display("FAIL rand_rsp%0d c=%0d v=%b exp=%b out=%h exp=%h z=%b exp=%b tag=%h exp=%h",
                                    i, c, rs_v[i], m_v[i], rs_o[i], m_o[i], rs_z[i], m_z[i], rs_t[i], m_t[i]);
                end
            end
            tick();
            for (int i = 0; i < 2; i++) if (g[i]) rq_v[i] = 0;
        end
        rq_v[0] = 0; rq_v[1] = 0; rs_r[0] = 1; rs_r[1] = 1;
        tick();
    endtask

`ifdef ALU_ARB_STATS_EN
    task automatic test_stats();
        do_reset();
        rs_r[0] = 1; rs_r[1] = 1;
        total++;
        if (sg0 !== 0 || sg1 !== 0 || scf !== 0) begin bad++; $display("FAIL stats_reset %0d/%0d/%0d exp 0/0/0", sg0, sg1, scf); end
        set_req(0, 1, 2, 3'd0, 0, 4'h0);
        set_req(1, 3, 4, 3'd0, 0, 4'h0);
        tick();
        tick();
        rq_v[1] = 0;
        tick();
        rq_v[0] = 0; rq_v[1] = 1;
        tick();
        rq_v[0] = 1; rq_v[1] = 0;
        tick();
        rq_v[0] = 0;
        tick();
        total++;
        if (sg0 !== 3 || sg1 !== 2 || scf !== 2) begin bad++; $display("FAIL stats_count %0d/%0d/%0d exp 3/2/2", sg0, sg1, scf); end
        rq_v[0] = 1;
        repeat (65540) tick();
        total++;
        if (sg0 !== 16'hFFFF || sg1 !== 2) begin bad++; $display("FAIL stats_sat g0=%h g1=%0d exp ffff/2", sg0, sg1); end
        stat_clr = 1;
        tick();
        stat_clr = 0;
        rq_v[0] = 0;
        total++;
        if (sg0 !== 0 || sg1 !== 0 || scf !== 0) begin bad++; $display("FAIL stats_clr %0d/%0d/%0d exp 0/0/0", sg0, sg1, scf); end
    endtask
`endif

    initial begin
        for (int i = 0; i < 2; i++) begin
            rq_v[i] = 0; rq_a[i] = 0; rq_b[i] = 0; rq_u[i] = 0; rq_f[i] = 0; rq_t[i] = 0; rs_r[i] = 0;
            m_v[i] = 0; m_o[i] = 0; m_z[i] = 0; m_t[i] = 0;
        end
        m_prio = 0;
        test_reset();
        test_single();
        test_alternate();
        test_blocked();
        test_drain_grant();
        test_reset_mid();
        test_random();
`ifdef ALU_ARB_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
